// File: rtl/counter_event_demux_tx.sv
`default_nettype none
// ============================================================================
// Module      : counter_event_demux_tx
// Description : COUNTER_NUM independent event channels. Each channel counts
//               incoming single-cycle events and drains them one at a time
//               as 4-phase request/acknowledge handshakes. Each transfer is
//               routed to lane a or lane b. The route is chosen by the
//               i_demux_sel value sampled when the transfer launches.
//               Events that arrive while the pending counter is full are
//               dropped and flagged in a sticky overflow bit.
// Ports       : i_clk       - sole clock (rising edge)
//               i_rst       - synchronous active-high reset
//               i_evt       - per-channel single-cycle event pulse
//               i_demux_sel - per-channel route select (0 = lane a, 1 = lane b)
//               i_ack_a     - lane-a acknowledge (synchronous to i_clk)
//               i_ack_b     - lane-b acknowledge (synchronous to i_clk)
//               i_ovf_clr   - clears every o_ovf bit
//               o_req_a     - lane-a 4-phase request (registered)
//               o_req_b     - lane-b 4-phase request (registered)
//               o_busy      - channel not idle or events pending (registered)
//               o_ovf       - sticky per-channel event-dropped flag
// Revision    : 1.0 - initial release
// ============================================================================
module counter_event_demux_tx #(
    parameter int COUNTER_NUM = 4,
    parameter int PEND_W      = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [COUNTER_NUM-1:0] i_evt,
    input  logic [COUNTER_NUM-1:0] i_demux_sel,
    input  logic [COUNTER_NUM-1:0] i_ack_a,
    input  logic [COUNTER_NUM-1:0] i_ack_b,
    input  logic                   i_ovf_clr,
    output logic [COUNTER_NUM-1:0] o_req_a,
    output logic [COUNTER_NUM-1:0] o_req_b,
    output logic [COUNTER_NUM-1:0] o_busy,
    output logic [COUNTER_NUM-1:0] o_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    localparam logic [PEND_W-1:0] C_PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] C_PEND_ONE = PEND_W'(1);

    generate
        for (genvar g = 0; g < COUNTER_NUM; g++) begin : g_ch
            state_t            r_state_q;
            state_t            w_state_d;
            logic [PEND_W-1:0] r_pend_q;
            logic [PEND_W-1:0] w_pend_d;
            logic              r_sel_q;
            logic              w_sel_d;
            logic              w_launch;
            logic              w_drop;
            logic              w_ack_sel;
            logic              r_req_a_q;
            logic              r_req_b_q;
            logic              r_busy_q;
            logic              r_ovf_q;

            // Next-state and pending-counter logic
            always_comb begin
                w_state_d = r_state_q;
                w_sel_d   = r_sel_q;
                w_pend_d  = r_pend_q;
                w_launch  = 1'b0;
                w_drop    = 1'b0;
                // Only the lane latched at launch is listened to; the
                // other lane's acknowledge has no effect in any state.
                w_ack_sel = r_sel_q ? i_ack_b[g] : i_ack_a[g];

                case (r_state_q)
                    ST_IDLE: begin
                        // A fresh event launches in its own cycle, so it
                        // never passes through the pending counter.
                        if ((r_pend_q != '0) || i_evt[g]) begin
                            w_launch  = 1'b1;
                            w_sel_d   = i_demux_sel[g];
                            w_state_d = ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (w_ack_sel) begin
                            w_state_d = ST_REL;
                        end
                    end
                    ST_REL: begin
                        // Always return through IDLE so the request stays
                        // low for at least one cycle between transfers.
                        if (!w_ack_sel) begin
                            w_state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        w_state_d = ST_IDLE;
                    end
                endcase

                // pend_next = pend + evt - launch, saturating at the maximum
                if (i_evt[g] && !w_launch) begin
                    if (r_pend_q == C_PEND_MAX) begin
                        w_drop = 1'b1;
                    end else begin
                        w_pend_d = r_pend_q + C_PEND_ONE;
                    end
                end else if (!i_evt[g] && w_launch) begin
                    w_pend_d = r_pend_q - C_PEND_ONE;
                end
            end

            // State register. The outputs are registered from next-state
            // values so they line up with the state they describe.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_state_q <= ST_IDLE;
                    r_pend_q  <= '0;
                    r_sel_q   <= 1'b0;
                    r_req_a_q <= 1'b0;
                    r_req_b_q <= 1'b0;
                    r_busy_q  <= 1'b0;
                    r_ovf_q   <= 1'b0;
                end else begin
                    r_state_q <= w_state_d;
                    r_pend_q  <= w_pend_d;
                    r_sel_q   <= w_sel_d;
                    r_req_a_q <= (w_state_d == ST_REQ) && !w_sel_d;
                    r_req_b_q <= (w_state_d == ST_REQ) && w_sel_d;
                    r_busy_q  <= (w_state_d != ST_IDLE) || (w_pend_d != '0);
                    // A drop in the same cycle as a clear leaves the bit set.
                    r_ovf_q   <= (r_ovf_q && !i_ovf_clr) || w_drop;
                end
            end

            assign o_req_a[g] = r_req_a_q;
            assign o_req_b[g] = r_req_b_q;
            assign o_busy[g]  = r_busy_q;
            assign o_ovf[g]   = r_ovf_q;
        end
    endgenerate

endmodule
`default_nettype wire
